// File: rtl/prt_lb_mux_tmo.sv
// prt_lb_mux_tmo: local-bus demultiplexer with one upstream master and
// P_PORTS downstream slaves. Writes are fire-and-forget. Reads block until
// the selected slave answers. Protocol errors set a sticky flag.
// Optional feature macro PRT_LB_MUX_TMO_EN adds a read timeout of P_TMO
// cycles. On expiry the module returns P_ERR_DAT and sets STA_TMO_OUT.
module prt_lb_mux_tmo #(
  parameter int          P_PORTS   = 11,
  parameter int          P_ADR_UP  = 22,
  parameter int          P_ADR_DWN = 16,
  parameter int          P_TMO     = 1024,
  parameter logic [31:0] P_ERR_DAT = 32'hDEADBEEF
) (
  input  logic                   CLK_IN,
  input  logic                   RST_IN,
  input  logic [P_ADR_UP-1:0]    UP_ADR_IN,
  input  logic                   UP_WR_IN,
  input  logic                   UP_RD_IN,
  input  logic [31:0]            UP_DAT_IN,
  output logic [31:0]            UP_DAT_OUT,
  output logic                   UP_VLD_OUT,
  output logic [P_ADR_DWN-1:0]   DWN_ADR_OUT,
  output logic [31:0]            DWN_DAT_OUT,
  output logic [P_PORTS-1:0]     DWN_WR_OUT,
  output logic [P_PORTS-1:0]     DWN_RD_OUT,
  input  logic [P_PORTS*32-1:0]  DWN_DAT_IN,
  input  logic [P_PORTS-1:0]     DWN_VLD_IN,
  output logic                   STA_TMO_OUT,
  output logic                   STA_ERR_OUT,
  input  logic                   STA_CLR_IN
);

  localparam int LP_SW = P_ADR_UP - P_ADR_DWN;
  localparam int LP_IW = (P_PORTS > 1) ? $clog2(P_PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_RESP} state_t;

  state_t               r_state, w_state_next;
  logic [LP_IW-1:0]     r_sel;
  logic [P_PORTS-1:0]   r_dwn_wr, r_dwn_rd;
  logic [P_ADR_DWN-1:0] r_dwn_adr;
  logic [31:0]          r_dwn_dat, r_up_dat;
  logic                 r_up_vld, r_err, r_tmo;

  logic [LP_SW-1:0]     w_sel;
  logic [LP_IW-1:0]     w_sel_idx;
  logic                 w_sel_ok;
  logic [P_PORTS-1:0]   w_onehot;
  logic [31:0]          w_dwn_dat [P_PORTS];
  logic [P_PORTS-1:0]   w_wr_next, w_rd_next;
  logic                 w_req_load, w_sel_load, w_cap_en, w_up_vld_next;
  logic [31:0]          w_cap_dat;
  logic                 w_err_set, w_tmo_set, w_tmo_hit;

  // Unpack the flat per-port read-data bus into an indexable array.
  generate
    for (genvar gi = 0; gi < P_PORTS; gi++) begin : g_unpack
      assign w_dwn_dat[gi] = DWN_DAT_IN[gi*32 +: 32];
    end
  endgenerate

  assign w_sel     = UP_ADR_IN[P_ADR_UP-1:P_ADR_DWN];
  assign w_sel_idx = w_sel[LP_IW-1:0];
  assign w_sel_ok  = ({{(32-LP_SW){1'b0}}, w_sel} < $unsigned(P_PORTS));
  assign w_onehot  = {{(P_PORTS-1){1'b0}}, 1'b1} << w_sel_idx;

`ifdef PRT_LB_MUX_TMO_EN
  logic [15:0] r_cnt;

  // Timeout counter: zero outside RD_WAIT, counts cycles spent waiting.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN)                    r_cnt <= '0;
    else if (r_state == ST_RD_WAIT) r_cnt <= r_cnt + 16'd1;
    else                            r_cnt <= '0;
  end

  // Expiry is reached on the P_TMO-th cycle in RD_WAIT.
  assign w_tmo_hit   = (r_cnt == 16'(P_TMO - 1));
  assign STA_TMO_OUT = r_tmo;
`else
  logic w_tmo_unused;
  assign w_tmo_unused = |16'(P_TMO) | r_tmo;
  assign w_tmo_hit    = 1'b0;
  assign STA_TMO_OUT  = 1'b0;
`endif

  // Next-state and request decode. A valid response has priority over timeout expiry.
  always_comb begin
    w_state_next  = r_state;
    w_wr_next     = '0;
    w_rd_next     = '0;
    w_req_load    = 1'b0;
    w_sel_load    = 1'b0;
    w_cap_en      = 1'b0;
    w_cap_dat     = P_ERR_DAT;
    w_up_vld_next = 1'b0;
    w_err_set     = 1'b0;
    w_tmo_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (UP_WR_IN && UP_RD_IN) begin
          w_err_set = 1'b1;
        end else if (UP_WR_IN) begin
          if (w_sel_ok) begin
            w_wr_next  = w_onehot;
            w_req_load = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (UP_RD_IN) begin
          if (w_sel_ok) begin
            w_rd_next    = w_onehot;
            w_req_load   = 1'b1;
            w_sel_load   = 1'b1;
            w_state_next = ST_RD_WAIT;
          end else begin
            // Unmapped port: answer immediately with the error pattern.
            w_err_set     = 1'b1;
            w_cap_en      = 1'b1;
            w_up_vld_next = 1'b1;
            w_state_next  = ST_RESP;
          end
        end
      end
      ST_RD_WAIT: begin
        w_err_set = UP_WR_IN | UP_RD_IN;
        if (DWN_VLD_IN[r_sel]) begin
          w_cap_en      = 1'b1;
          w_cap_dat     = w_dwn_dat[r_sel];
          w_up_vld_next = 1'b1;
          w_state_next  = ST_RESP;
        end else if (w_tmo_hit) begin
          w_cap_en      = 1'b1;
          w_tmo_set     = 1'b1;
          w_up_vld_next = 1'b1;
          w_state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        w_err_set    = UP_WR_IN | UP_RD_IN;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register and registered datapath/strobe outputs.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_dwn_wr  <= '0;
      r_dwn_rd  <= '0;
      r_dwn_adr <= '0;
      r_dwn_dat <= '0;
      r_up_dat  <= '0;
      r_up_vld  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_dwn_wr <= w_wr_next;
      r_dwn_rd <= w_rd_next;
      r_up_vld <= w_up_vld_next;
      if (w_sel_load) r_sel <= w_sel_idx;
      if (w_req_load) begin
        r_dwn_adr <= UP_ADR_IN[P_ADR_DWN-1:0];
        r_dwn_dat <= UP_DAT_IN;
      end
      if (w_cap_en) r_up_dat <= w_cap_dat;
    end
  end

  // Sticky status flags; a set event in the same cycle beats a clear.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_err <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      if (w_err_set)       r_err <= 1'b1;
      else if (STA_CLR_IN) r_err <= 1'b0;
      if (w_tmo_set)       r_tmo <= 1'b1;
      else if (STA_CLR_IN) r_tmo <= 1'b0;
    end
  end

  assign UP_DAT_OUT  = r_up_dat;
  assign UP_VLD_OUT  = r_up_vld;
  assign DWN_ADR_OUT = r_dwn_adr;
  assign DWN_DAT_OUT = r_dwn_dat;
  assign DWN_WR_OUT  = r_dwn_wr;
  assign DWN_RD_OUT  = r_dwn_rd;
  assign STA_ERR_OUT = r_err;

endmodule

// File: tb/tb_prt_lb_mux_tmo.sv
// Directed testbench for prt_lb_mux_tmo (P_PORTS=11, P_TMO=16).
// Timeout checks are compiled in when PRT_LB_MUX_TMO_EN is defined.
module tb_prt_lb_mux_tmo;
  localparam int NP = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [21:0]   up_adr;
  logic          up_wr, up_rd, sta_clr;
  logic [31:0]   up_dat_in, up_dat_out, dwn_dat_out;
  logic          up_vld, sta_tmo, sta_err;
  logic [15:0]   dwn_adr;
  logic [NP-1:0] dwn_wr, dwn_rd, dwn_vld;
  logic [NP*32-1:0] dwn_dat_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prt_lb_mux_tmo #(.P_PORTS(NP), .P_ADR_UP(22), .P_ADR_DWN(16), .P_TMO(16),
                   .P_ERR_DAT(32'hDEADBEEF)) dut (
    .CLK_IN(clk), .RST_IN(rst_n),
    .UP_ADR_IN(up_adr), .UP_WR_IN(up_wr), .UP_RD_IN(up_rd),
    .UP_DAT_IN(up_dat_in), .UP_DAT_OUT(up_dat_out), .UP_VLD_OUT(up_vld),
    .DWN_ADR_OUT(dwn_adr), .DWN_DAT_OUT(dwn_dat_out),
    .DWN_WR_OUT(dwn_wr), .DWN_RD_OUT(dwn_rd),
    .DWN_DAT_IN(dwn_dat_in), .DWN_VLD_IN(dwn_vld),
    .STA_TMO_OUT(sta_tmo), .STA_ERR_OUT(sta_err), .STA_CLR_IN(sta_clr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    up_wr = 1'b0; up_rd = 1'b0; sta_clr = 1'b0; dwn_vld = '0;
  endtask

  task automatic req(input logic wr, input logic rd, input logic [21:0] adr, input logic [31:0] dat);
    up_wr = wr; up_rd = rd; up_adr = adr; up_dat_in = dat;
    step();
    up_wr = 1'b0; up_rd = 1'b0;
  endtask

  task automatic clear_flags();
    sta_clr = 1'b1;
    step();
    sta_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_updat"}, 64'(up_dat_out), 64'h0);
    check({tag, "_upvld"}, 64'(up_vld), 64'h0);
    check({tag, "_adr"},   64'(dwn_adr), 64'h0);
    check({tag, "_ddat"},  64'(dwn_dat_out), 64'h0);
    check({tag, "_wr"},    64'(dwn_wr), 64'h0);
    check({tag, "_rd"},    64'(dwn_rd), 64'h0);
    check({tag, "_err"},   64'(sta_err), 64'h0);
    check({tag, "_tmo"},   64'(sta_tmo), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; up_adr = '0; up_dat_in = '0; dwn_dat_in = '0;
    idle_in();
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Write to port 4, issued on the first edge after reset release.
    req(1'b1, 1'b0, 22'h04_0010, 32'h12345678);
    check("wr_strobe", 64'(dwn_wr), 64'h010);
    check("wr_adr",    64'(dwn_adr), 64'h0010);
    check("wr_dat",    64'(dwn_dat_out), 64'h12345678);
    check("wr_nord",   64'(dwn_rd), 64'h0);
    step();
    check("wr_pulse1", 64'(dwn_wr), 64'h0);
    check("wr_noerr",  64'(sta_err), 64'h0);

    // Last valid port (10).
    req(1'b1, 1'b0, 22'h0A_ABCD, 32'h0BADF00D);
    check("wr10_strobe", 64'(dwn_wr), 64'h400);
    check("wr10_adr",    64'(dwn_adr), 64'hABCD);
    step();

    // Read port 2; valid arrives 3 cycles after the strobe, with a stray port-5 valid.
    req(1'b0, 1'b1, 22'h02_0044, 32'h0);
    check("rd2_strobe", 64'(dwn_rd), 64'h004);
    check("rd2_adr",    64'(dwn_adr), 64'h0044);
    dwn_dat_in[5*32 +: 32] = 32'h55555555;
    dwn_vld[5] = 1'b1;
    step();
    dwn_vld = '0;
    check("rd2_rdpulse", 64'(dwn_rd), 64'h0);
    check("rd2_ignore5", 64'(up_vld), 64'h0);
    step();
    check("rd2_wait", 64'(up_vld), 64'h0);
    dwn_dat_in[2*32 +: 32] = 32'hCAFE0001;
    dwn_vld[2] = 1'b1;
    step();
    dwn_vld = '0;
    check("rd2_vld", 64'(up_vld), 64'h1);
    check("rd2_dat", 64'(up_dat_out), 64'hCAFE0001);
    step();
    check("rd2_vld1cyc", 64'(up_vld), 64'h0);
    check("rd2_hold",    64'(up_dat_out), 64'hCAFE0001);
    check("rd2_noerr",   64'(sta_err), 64'h0);

    // Idle-state valid is ignored.
    dwn_dat_in[2*32 +: 32] = 32'h77777777;
    dwn_vld[2] = 1'b1;
    step();
    dwn_vld = '0;
    check("idle_vld_ign", 64'(up_vld), 64'h0);
    check("idle_vld_dat", 64'(up_dat_out), 64'hCAFE0001);

    // Read of unmapped port 15.
    req(1'b0, 1'b1, 22'h0F_0000, 32'h0);
    check("rd15_vld",  64'(up_vld), 64'h1);
    check("rd15_dat",  64'(up_dat_out), 64'hDEADBEEF);
    check("rd15_err",  64'(sta_err), 64'h1);
    check("rd15_nord", 64'(dwn_rd), 64'h0);
    check("rd15_nowr", 64'(dwn_wr), 64'h0);
    step();
    check("rd15_vld1cyc", 64'(up_vld), 64'h0);
    clear_flags();
    check("clr_err", 64'(sta_err), 64'h0);

    // Write to port 11 (first unmapped) is dropped.
    req(1'b1, 1'b0, 22'h0B_0000, 32'h11111111);
    check("wr11_nowr", 64'(dwn_wr), 64'h0);
    check("wr11_err",  64'(sta_err), 64'h1);
    clear_flags();

    // Simultaneous write and read.
    req(1'b1, 1'b1, 22'h01_0000, 32'h22222222);
    check("both_nowr", 64'(dwn_wr), 64'h0);
    check("both_nord", 64'(dwn_rd), 64'h0);
    check("both_err",  64'(sta_err), 64'h1);
    clear_flags();

    // Set beats clear in the same cycle.
    sta_clr = 1'b1;
    req(1'b1, 1'b0, 22'h20_0000, 32'h0);
    sta_clr = 1'b0;
    check("setwins_err", 64'(sta_err), 64'h1);
    clear_flags();

    // Pending read on port 3; second read plus port-5 valid are rejected.
    req(1'b0, 1'b1, 22'h03_0008, 32'h0);
    check("rd3_strobe", 64'(dwn_rd), 64'h008);
    dwn_vld[5] = 1'b1;
    req(1'b0, 1'b1, 22'h01_0000, 32'h0);
    dwn_vld = '0;
    check("rd3_2nd_nord", 64'(dwn_rd), 64'h0);
    check("rd3_2nd_err",  64'(sta_err), 64'h1);
    check("rd3_wrongvld", 64'(up_vld), 64'h0);
    clear_flags();
    check("rd3_clr", 64'(sta_err), 64'h0);
    dwn_dat_in[3*32 +: 32] = 32'h33330003;
    dwn_vld[3] = 1'b1;
    step();
    dwn_vld = '0;
    check("rd3_vld", 64'(up_vld), 64'h1);
    check("rd3_dat", 64'(up_dat_out), 64'h33330003);
    // Strobe during RESP is dropped.
    req(1'b1, 1'b0, 22'h00_0000, 32'h44444444);
    check("resp_nowr", 64'(dwn_wr), 64'h0);
    check("resp_err",  64'(sta_err), 64'h1);
    check("resp_vld0", 64'(up_vld), 64'h0);
    clear_flags();

    // Reset during RD_WAIT abandons the read.
    req(1'b0, 1'b1, 22'h04_0000, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("rstmid");
    step();
    rst_n = 1'b1;
    dwn_dat_in[4*32 +: 32] = 32'h44440004;
    dwn_vld[4] = 1'b1;
    step(3);
    dwn_vld = '0;
    check("rstmid_late_vld", 64'(up_vld), 64'h0);
    check("rstmid_late_dat", 64'(up_dat_out), 64'h0);
    check("rstmid_late_rd",  64'(dwn_rd), 64'h0);

`ifdef PRT_LB_MUX_TMO_EN
    // No valid: timeout on the 16th waiting cycle.
    req(1'b0, 1'b1, 22'h06_0000, 32'h0);
    step(15);
    check("tmo_before", 64'(up_vld), 64'h0);
    step();
    check("tmo_vld", 64'(up_vld), 64'h1);
    check("tmo_dat", 64'(up_dat_out), 64'hDEADBEEF);
    check("tmo_flag", 64'(sta_tmo), 64'h1);
    check("tmo_noerr", 64'(sta_err), 64'h0);
    clear_flags();
    check("tmo_clr", 64'(sta_tmo), 64'h0);
    // Valid on the 16th cycle beats expiry.
    req(1'b0, 1'b1, 22'h06_0000, 32'h0);
    step(15);
    dwn_dat_in[6*32 +: 32] = 32'h66660006;
    dwn_vld[6] = 1'b1;
    step();
    dwn_vld = '0;
    check("tmo_race_vld", 64'(up_vld), 64'h1);
    check("tmo_race_dat", 64'(up_dat_out), 64'h66660006);
    check("tmo_race_flag", 64'(sta_tmo), 64'h0);
    step();
`else
    // Without the timeout the read waits indefinitely.
    req(1'b0, 1'b1, 22'h06_0000, 32'h0);
    step(40);
    check("notmo_wait", 64'(up_vld), 64'h0);
    check("notmo_flag", 64'(sta_tmo), 64'h0);
    dwn_dat_in[6*32 +: 32] = 32'h66660006;
    dwn_vld[6] = 1'b1;
    step();
    dwn_vld = '0;
    check("notmo_vld", 64'(up_vld), 64'h1);
    check("notmo_dat", 64'(up_dat_out), 64'h66660006);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
